axis_deparser_arb: RTL and testbench
====================================

# axis_deparser_arb

Packet-level round-robin arbiter that shares one `axis_deparser` instance between `S_COUNT` header-modify pipelines. Each requester presents a single-beat header stream and a matching payload stream. The arbiter grants one requester at a time and forwards that requester's header beat and whole payload frame to the deparser inputs. It releases the grant on the payload `tlast` handshake. The block sits directly in front of the deparser and uses zero-latency passthrough muxing with a registered grant.

## Interface
Parameters:
- `S_COUNT`, 4: number of requesters, 2..16.
- `DATA_WIDTH`, 512: payload tdata width.
- `KEEP_WIDTH`, DATA_WIDTH/8: payload tkeep width.
- `HDR_DATA_WIDTH`, 560: header tdata width.
- `HDR_KEEP_WIDTH`, HDR_DATA_WIDTH/8: header tkeep width.
- `ID_WIDTH`, 8 / `DEST_WIDTH`, 4 / `USER_WIDTH`, 4: sideband widths, shared by header and payload.
- `CL_S_COUNT`, $clog2(S_COUNT): grant index width (derived).

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s_axis_hdr_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser`  in (tready out)  S_COUNT×width  requester header streams, concatenated with port 0 in the LSBs.
- `s_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser`  in (tready out)  S_COUNT×width  requester payload streams, same packing.
- `m_axis_hdr_*`  out (tready in)  single width  header to the deparser.
- `m_axis_*`  out (tready in)  single width  payload to the deparser.
- `grant_valid`  out  1  a packet is in flight.
- `grant_index`  out  CL_S_COUNT  index of the granted requester.
- `pkt_count`  out  32  number of completed packets, wrapping.

## Operation
- The FSM has two states, `ST_IDLE` and `ST_ACTIVE`. Registers: `grant_reg`, `ptr_reg` (round-robin pointer), `hdr_done_reg`, `pkt_count_reg`.
- `ST_IDLE`:
  - All s-side treadies and all m-side tvalids are 0.
  - If any bit of `s_axis_hdr_tvalid` is set, select the first set bit searching from `ptr_reg` upward, wrapping modulo S_COUNT.
  - Load that index into `grant_reg`, clear `hdr_done_reg`, and go to `ST_ACTIVE`.
  - Payload tvalid alone never triggers a grant.
- `ST_ACTIVE`, with g = `grant_reg`:
  - Header path: `m_axis_hdr_tvalid = s_axis_hdr_tvalid[g] && !hdr_done_reg`. `s_axis_hdr_tready[g] = m_axis_hdr_tready && !hdr_done_reg`. All other header fields are muxed from port g. A header handshake sets `hdr_done_reg`. Header tlast is passed through and otherwise ignored, because the header is always one beat.
  - Payload path: `m_axis_tvalid = s_axis_tvalid[g]` and `s_axis_tready[g] = m_axis_tready`. All fields are muxed from port g.
  - The payload path is open from the first `ST_ACTIVE` cycle. The deparser accepts its first payload beat in the same cycle as the header, and this must pass through.
  - A payload handshake with tlast=1 does four things: go to `ST_IDLE`, set `ptr_reg = (g+1) mod S_COUNT`, increment `pkt_count_reg`, and clear `hdr_done_reg`.
- Non-granted ports always see tready=0.
- `grant_valid = (state == ST_ACTIVE)`. `grant_index = grant_reg`.
- Payload tlast arriving before the header handshake is a protocol error from the deparser side. The arbiter does not police it and still releases on it.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert through the existing flop style) sets:
  - state `ST_IDLE`, `grant_reg`=0, `ptr_reg`=0, `hdr_done_reg`=0, `pkt_count`=0.
  - All m-side tvalid=0 and all s-side tready=0, immediately on assert.
- Arbitration latency: a header presented in cycle N can first appear on `m_axis_hdr_tvalid` in cycle N+1.
- Inter-packet bubble: exactly one `ST_IDLE` cycle between the tlast handshake and the next grant.
- Data and ready paths are combinational through the muxes. The block adds no register stage on data.
- If the granted requester drops tvalid mid-packet, the grant is held indefinitely. There is no timeout.
- A new requester asserting tvalid during `ST_ACTIVE` does not preempt the current grant.
- Reset mid-packet abandons the packet. Requesters must be reset together with the arbiter.
- `pkt_count` wraps from 0xFFFFFFFF to 0.

## Test plan
- **Single requester:** port 2 sends a header plus a 3-beat payload, with m treadies held at 1.
  - `grant_index`=2 from cycle 1.
  - The header and payload beat 0 handshake in the same cycle.
  - `ST_IDLE` is re-entered after beat 2; `pkt_count`=1; `ptr`=3.
- **Contention:** ports 0, 1 and 3 assert header tvalid simultaneously from reset, each with 2-beat payloads.
  - Grant order is 0, 1, 3.
  - Exactly one idle cycle separates each packet.
  - `pkt_count`=3 at the end.
- **Pointer wrap:** with `ptr`=3, ports 0 and 3 request. Port 3 is granted first, then port 0.
- **Backpressure:** toggle `m_axis_tready` 1,0,1,0 during a 4-beat payload.
  - `s_axis_tready[g]` mirrors it exactly.
  - The data on m_axis matches beat for beat.
  - Non-granted treadies stay at 0.
- **Single-beat payload:** the header and a tlast=1 payload beat are accepted in the same cycle.
  - The arbiter returns to `ST_IDLE` next cycle.
  - `hdr_done` is cleared.
- **Reset mid-packet:** assert `rst_n`=0 during beat 1 of a 4-beat packet.
  - `m_axis_tvalid` and `m_axis_hdr_tvalid` fall in the same cycle.
  - `grant_valid`=0 and `pkt_count`=0.
  - After release, a new packet from port 1 is granted normally.

Source files
------------

// File: rtl/axis_deparser_arb.sv
// Packet-level round-robin arbiter sharing one axis_deparser among S_COUNT requesters.
// The grant is registered; header and payload paths are zero-latency muxes from the granted port.
module axis_deparser_arb #(
    parameter int unsigned S_COUNT        = 4,
    parameter int unsigned DATA_WIDTH     = 512,
    parameter int unsigned KEEP_WIDTH     = DATA_WIDTH / 8,
    parameter int unsigned HDR_DATA_WIDTH = 560,
    parameter int unsigned HDR_KEEP_WIDTH = HDR_DATA_WIDTH / 8,
    parameter int unsigned ID_WIDTH       = 8,
    parameter int unsigned DEST_WIDTH     = 4,
    parameter int unsigned USER_WIDTH     = 4,
    parameter int unsigned CL_S_COUNT     = $clog2(S_COUNT)
) (
    input  logic                             clk,
    input  logic                             rst_n,

    input  logic [S_COUNT*HDR_DATA_WIDTH-1:0] s_axis_hdr_tdata,
    input  logic [S_COUNT*HDR_KEEP_WIDTH-1:0] s_axis_hdr_tkeep,
    input  logic [S_COUNT-1:0]                s_axis_hdr_tvalid,
    output logic [S_COUNT-1:0]                s_axis_hdr_tready,
    input  logic [S_COUNT-1:0]                s_axis_hdr_tlast,
    input  logic [S_COUNT*ID_WIDTH-1:0]       s_axis_hdr_tid,
    input  logic [S_COUNT*DEST_WIDTH-1:0]     s_axis_hdr_tdest,
    input  logic [S_COUNT*USER_WIDTH-1:0]     s_axis_hdr_tuser,

    input  logic [S_COUNT*DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [S_COUNT*KEEP_WIDTH-1:0]     s_axis_tkeep,
    input  logic [S_COUNT-1:0]                s_axis_tvalid,
    output logic [S_COUNT-1:0]                s_axis_tready,
    input  logic [S_COUNT-1:0]                s_axis_tlast,
    input  logic [S_COUNT*ID_WIDTH-1:0]       s_axis_tid,
    input  logic [S_COUNT*DEST_WIDTH-1:0]     s_axis_tdest,
    input  logic [S_COUNT*USER_WIDTH-1:0]     s_axis_tuser,

    output logic [HDR_DATA_WIDTH-1:0]         m_axis_hdr_tdata,
    output logic [HDR_KEEP_WIDTH-1:0]         m_axis_hdr_tkeep,
    output logic                              m_axis_hdr_tvalid,
    input  logic                              m_axis_hdr_tready,
    output logic                              m_axis_hdr_tlast,
    output logic [ID_WIDTH-1:0]               m_axis_hdr_tid,
    output logic [DEST_WIDTH-1:0]             m_axis_hdr_tdest,
    output logic [USER_WIDTH-1:0]             m_axis_hdr_tuser,

    output logic [DATA_WIDTH-1:0]             m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]             m_axis_tkeep,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,
    output logic [ID_WIDTH-1:0]               m_axis_tid,
    output logic [DEST_WIDTH-1:0]             m_axis_tdest,
    output logic [USER_WIDTH-1:0]             m_axis_tuser,

    output logic                              grant_valid,
    output logic [CL_S_COUNT-1:0]             grant_index,
    output logic [31:0]                       pkt_count
);

    localparam int unsigned PTR_MAX = S_COUNT - 1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [CL_S_COUNT-1:0] grant_q, grant_d;
    logic [CL_S_COUNT-1:0] ptr_q, ptr_d;
    logic                  hdr_done_q, hdr_done_d;
    logic [31:0]           pkt_count_q, pkt_count_d;

    logic                  active;
    logic                  hdr_hs;
    logic                  pay_last_hs;
    logic                  rr_found;
    logic [CL_S_COUNT-1:0] rr_sel;
    logic [CL_S_COUNT-1:0] rr_idx;
    int unsigned           rr_sum;

    assign active      = (state_q == ST_ACTIVE);
    assign grant_valid = active;
    assign grant_index = grant_q;
    assign pkt_count   = pkt_count_q;

    // First requesting header port at or above the pointer, wrapping modulo S_COUNT.
    always_comb begin
        rr_found = 1'b0;
        rr_sel   = '0;
        rr_idx   = '0;
        rr_sum   = 0;
        for (int unsigned i = 0; i < S_COUNT; i++) begin
            rr_sum = 32'(ptr_q) + i;
            if (rr_sum >= S_COUNT) begin
                rr_sum = rr_sum - S_COUNT;
            end
            rr_idx = CL_S_COUNT'(rr_sum);
            if (!rr_found && s_axis_hdr_tvalid[rr_idx]) begin
                rr_found = 1'b1;
                rr_sel   = rr_idx;
            end
        end
    end

    // Passthrough muxes; only the granted port ever sees tready.
    always_comb begin
        s_axis_hdr_tready = '0;
        s_axis_tready     = '0;
        m_axis_hdr_tvalid = 1'b0;
        m_axis_tvalid     = 1'b0;

        m_axis_hdr_tdata  = s_axis_hdr_tdata[grant_q*HDR_DATA_WIDTH +: HDR_DATA_WIDTH];
        m_axis_hdr_tkeep  = s_axis_hdr_tkeep[grant_q*HDR_KEEP_WIDTH +: HDR_KEEP_WIDTH];
        m_axis_hdr_tlast  = s_axis_hdr_tlast[grant_q];
        m_axis_hdr_tid    = s_axis_hdr_tid[grant_q*ID_WIDTH +: ID_WIDTH];
        m_axis_hdr_tdest  = s_axis_hdr_tdest[grant_q*DEST_WIDTH +: DEST_WIDTH];
        m_axis_hdr_tuser  = s_axis_hdr_tuser[grant_q*USER_WIDTH +: USER_WIDTH];

        m_axis_tdata      = s_axis_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
        m_axis_tkeep      = s_axis_tkeep[grant_q*KEEP_WIDTH +: KEEP_WIDTH];
        m_axis_tlast      = s_axis_tlast[grant_q];
        m_axis_tid        = s_axis_tid[grant_q*ID_WIDTH +: ID_WIDTH];
        m_axis_tdest      = s_axis_tdest[grant_q*DEST_WIDTH +: DEST_WIDTH];
        m_axis_tuser      = s_axis_tuser[grant_q*USER_WIDTH +: USER_WIDTH];

        if (active) begin
            m_axis_hdr_tvalid          = s_axis_hdr_tvalid[grant_q] && !hdr_done_q;
            s_axis_hdr_tready[grant_q] = m_axis_hdr_tready && !hdr_done_q;
            m_axis_tvalid              = s_axis_tvalid[grant_q];
            s_axis_tready[grant_q]     = m_axis_tready;
        end
    end

    assign hdr_hs      = m_axis_hdr_tvalid && m_axis_hdr_tready;
    assign pay_last_hs = m_axis_tvalid && m_axis_tready && m_axis_tlast;

    // Grant on header request; release on the payload tlast handshake.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        hdr_done_d  = hdr_done_q;
        pkt_count_d = pkt_count_q;

        case (state_q)
            ST_IDLE: begin
                if (rr_found) begin
                    grant_d    = rr_sel;
                    hdr_done_d = 1'b0;
                    state_d    = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (hdr_hs) begin
                    hdr_done_d = 1'b1;
                end
                if (pay_last_hs) begin
                    state_d     = ST_IDLE;
                    ptr_d       = (grant_q == CL_S_COUNT'(PTR_MAX)) ? '0 : grant_q + CL_S_COUNT'(1);
                    pkt_count_d = pkt_count_q + 32'd1;
                    hdr_done_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            ptr_q       <= '0;
            hdr_done_q  <= 1'b0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            hdr_done_q  <= hdr_done_d;
            pkt_count_q <= pkt_count_d;
        end
    end

endmodule

// File: tb/tb_axis_deparser_arb.sv
// Bench for axis_deparser_arb: directed scenarios plus randomized traffic, every cycle
// compared against a packet-level arbitration model.
`timescale 1ns/1ps
module tb_axis_deparser_arb;

    localparam int unsigned S   = 4;
    localparam int unsigned DW  = 32;
    localparam int unsigned KW  = DW / 8;
    localparam int unsigned HW  = 48;
    localparam int unsigned HKW = HW / 8;
    localparam int unsigned IW  = 8;
    localparam int unsigned DSW = 4;
    localparam int unsigned UW  = 4;
    localparam int unsigned CL  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [S*HW-1:0]  s_hdr_tdata;
    logic [S*HKW-1:0] s_hdr_tkeep;
    logic [S-1:0]     s_hdr_tvalid, s_hdr_tready, s_hdr_tlast;
    logic [S*IW-1:0]  s_hdr_tid;
    logic [S*DSW-1:0] s_hdr_tdest;
    logic [S*UW-1:0]  s_hdr_tuser;
    logic [S*DW-1:0]  s_tdata;
    logic [S*KW-1:0]  s_tkeep;
    logic [S-1:0]     s_tvalid, s_tready, s_tlast;
    logic [S*IW-1:0]  s_tid;
    logic [S*DSW-1:0] s_tdest;
    logic [S*UW-1:0]  s_tuser;

    logic [HW-1:0]  m_hdr_tdata;
    logic [HKW-1:0] m_hdr_tkeep;
    logic           m_hdr_tvalid, m_hdr_tready, m_hdr_tlast;
    logic [IW-1:0]  m_hdr_tid;
    logic [DSW-1:0] m_hdr_tdest;
    logic [UW-1:0]  m_hdr_tuser;
    logic [DW-1:0]  m_tdata;
    logic [KW-1:0]  m_tkeep;
    logic           m_tvalid, m_tready, m_tlast;
    logic [IW-1:0]  m_tid;
    logic [DSW-1:0] m_tdest;
    logic [UW-1:0]  m_tuser;

    logic           grant_valid;
    logic [CL-1:0]  grant_index;
    logic [31:0]    pkt_count;

    axis_deparser_arb #(
        .S_COUNT(S), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .HDR_DATA_WIDTH(HW), .HDR_KEEP_WIDTH(HKW),
        .ID_WIDTH(IW), .DEST_WIDTH(DSW), .USER_WIDTH(UW), .CL_S_COUNT(CL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_hdr_tdata(s_hdr_tdata), .s_axis_hdr_tkeep(s_hdr_tkeep),
        .s_axis_hdr_tvalid(s_hdr_tvalid), .s_axis_hdr_tready(s_hdr_tready),
        .s_axis_hdr_tlast(s_hdr_tlast), .s_axis_hdr_tid(s_hdr_tid),
        .s_axis_hdr_tdest(s_hdr_tdest), .s_axis_hdr_tuser(s_hdr_tuser),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
        .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
        .m_axis_hdr_tdata(m_hdr_tdata), .m_axis_hdr_tkeep(m_hdr_tkeep),
        .m_axis_hdr_tvalid(m_hdr_tvalid), .m_axis_hdr_tready(m_hdr_tready),
        .m_axis_hdr_tlast(m_hdr_tlast), .m_axis_hdr_tid(m_hdr_tid),
        .m_axis_hdr_tdest(m_hdr_tdest), .m_axis_hdr_tuser(m_hdr_tuser),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tid(m_tid),
        .m_axis_tdest(m_tdest), .m_axis_tuser(m_tuser),
        .grant_valid(grant_valid), .grant_index(grant_index), .pkt_count(pkt_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Packet-level reference: who owns the deparser, whether its header went through.
    int          owner;
    bit          taken;
    int          ptr;
    int unsigned count;

    // Requester drivers.
    bit hdr_pend   [S];
    bit active     [S];
    int beats_left [S];
    int pkts_left  [S];
    int fixed_len  [S];
    bit hdr_hs     [S];
    bit pay_hs     [S];
    int gap_pct;
    int tr_mode;
    int bp_phase;

    // Observations of the DUT.
    bit prev_gv;
    bit in_gap;
    int idle_run;
    int gaps_q[$];
    int grants_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic bit roll();
        return (gap_pct == 0) || ($urandom_range(0, 99) >= gap_pct);
    endfunction

    function automatic bit busy();
        bit b;
        b = (owner >= 0);
        for (int p = 0; p < S; p++) begin
            if (active[p] || pkts_left[p] > 0) b = 1'b1;
        end
        return b;
    endfunction

    task automatic clear_all();
        s_hdr_tdata = '0; s_hdr_tkeep = '0; s_hdr_tvalid = '0; s_hdr_tlast = '0;
        s_hdr_tid = '0; s_hdr_tdest = '0; s_hdr_tuser = '0;
        s_tdata = '0; s_tkeep = '0; s_tvalid = '0; s_tlast = '0;
        s_tid = '0; s_tdest = '0; s_tuser = '0;
        m_hdr_tready = 1'b0; m_tready = 1'b0;
        for (int p = 0; p < S; p++) begin
            hdr_pend[p] = 0; active[p] = 0; beats_left[p] = 0; pkts_left[p] = 0;
            fixed_len[p] = 0; hdr_hs[p] = 0; pay_hs[p] = 0;
        end
        owner = -1; taken = 0; ptr = 0; count = 0;
        prev_gv = 0; in_gap = 0; idle_run = 0;
    endtask

    // Compare every visible output with what the arbitration rules require.
    task automatic sample();
        int g;
        logic [S-1:0] e_htr, e_str;
        logic e_hv, e_pv;
        g = 0; e_htr = '0; e_str = '0; e_hv = 1'b0; e_pv = 1'b0;
        for (int p = 0; p < S; p++) begin
            hdr_hs[p] = 0; pay_hs[p] = 0;
        end
        if (owner >= 0) begin
            g = owner;
            e_hv = s_hdr_tvalid[g] && !taken;
            e_pv = s_tvalid[g];
            e_htr[g] = m_hdr_tready && !taken;
            e_str[g] = m_tready;
        end
        chk("grant_valid", 64'(grant_valid), 64'(owner >= 0));
        if (owner >= 0) chk("grant_index", 64'(grant_index), 64'(g));
        chk("pkt_count", 64'(pkt_count), 64'(count));
        chk("m_hdr_tvalid", 64'(m_hdr_tvalid), 64'(e_hv));
        chk("m_tvalid", 64'(m_tvalid), 64'(e_pv));
        chk("s_hdr_tready", 64'(s_hdr_tready), 64'(e_htr));
        chk("s_tready", 64'(s_tready), 64'(e_str));
        if (e_hv) begin
            chk("m_hdr_tdata", 64'(m_hdr_tdata), 64'(s_hdr_tdata[g*HW +: HW]));
            chk("m_hdr_side", 64'({m_hdr_tkeep, m_hdr_tlast, m_hdr_tid, m_hdr_tdest, m_hdr_tuser}),
                64'({s_hdr_tkeep[g*HKW +: HKW], s_hdr_tlast[g], s_hdr_tid[g*IW +: IW],
                     s_hdr_tdest[g*DSW +: DSW], s_hdr_tuser[g*UW +: UW]}));
            if (m_hdr_tready) hdr_hs[g] = 1;
        end
        if (e_pv) begin
            chk("m_tdata", 64'(m_tdata), 64'(s_tdata[g*DW +: DW]));
            chk("m_side", 64'({m_tkeep, m_tlast, m_tid, m_tdest, m_tuser}),
                64'({s_tkeep[g*KW +: KW], s_tlast[g], s_tid[g*IW +: IW],
                     s_tdest[g*DSW +: DSW], s_tuser[g*UW +: UW]}));
            if (m_tready) pay_hs[g] = 1;
        end
        if (grant_valid && !prev_gv) grants_q.push_back(int'(grant_index));
        if (prev_gv && !grant_valid) begin
            in_gap = 1; idle_run = 1;
        end else if (!grant_valid && in_gap) begin
            idle_run++;
        end else if (grant_valid && in_gap) begin
            gaps_q.push_back(idle_run); in_gap = 0;
        end
        prev_gv = grant_valid;
    endtask

    task automatic model_step();
        int p;
        if (owner < 0) begin
            for (int i = 0; i < S; i++) begin
                p = (ptr + i) % S;
                if (owner < 0 && s_hdr_tvalid[p]) begin
                    owner = p; taken = 0;
                end
            end
        end else begin
            if (hdr_hs[owner]) taken = 1;
            if (pay_hs[owner] && s_tlast[owner]) begin
                ptr = (owner + 1) % S;
                count++;
                owner = -1;
                taken = 0;
            end
        end
    endtask

    task automatic drive();
        bit mh, mt;
        for (int p = 0; p < S; p++) begin
            if (hdr_hs[p]) begin hdr_pend[p] = 0; s_hdr_tvalid[p] = 1'b0; end
            if (pay_hs[p]) begin beats_left[p]--; s_tvalid[p] = 1'b0; end
            hdr_hs[p] = 0; pay_hs[p] = 0;
            if (active[p] && !hdr_pend[p] && beats_left[p] == 0) active[p] = 0;
            if (!active[p] && pkts_left[p] > 0) begin
                active[p] = 1; pkts_left[p]--; hdr_pend[p] = 1;
                beats_left[p] = (fixed_len[p] > 0) ? fixed_len[p] : int'($urandom_range(1, 4));
            end
            if (hdr_pend[p] && !s_hdr_tvalid[p] && roll()) begin
                s_hdr_tvalid[p] = 1'b1;
                s_hdr_tdata[p*HW +: HW]    = HW'(rnd64());
                s_hdr_tkeep[p*HKW +: HKW]  = HKW'($urandom());
                s_hdr_tlast[p]             = 1'b1;
                s_hdr_tid[p*IW +: IW]      = IW'($urandom());
                s_hdr_tdest[p*DSW +: DSW]  = DSW'($urandom());
                s_hdr_tuser[p*UW +: UW]    = UW'($urandom());
            end
            if (active[p] && beats_left[p] > 0 && !s_tvalid[p] && roll()) begin
                s_tvalid[p] = 1'b1;
                s_tdata[p*DW +: DW]    = DW'($urandom());
                s_tkeep[p*KW +: KW]    = KW'($urandom());
                s_tlast[p]             = (beats_left[p] == 1);
                s_tid[p*IW +: IW]      = IW'($urandom());
                s_tdest[p*DSW +: DSW]  = DSW'($urandom());
                s_tuser[p*UW +: UW]    = UW'($urandom());
            end
        end
        case (tr_mode)
            1: begin
                mh = 1'b1;
                mt = (bp_phase % 2 == 0);
                if (owner >= 0) bp_phase++;
            end
            2: begin
                mh = ($urandom_range(0, 9) < 7);
                mt = ($urandom_range(0, 9) < 7);
            end
            default: begin mh = 1'b1; mt = 1'b1; end
        endcase
        // A well-behaved deparser takes payload only together with or after the header.
        if (owner >= 0 && !taken && !(mh && s_hdr_tvalid[owner])) mt = 1'b0;
        m_hdr_tready = mh;
        m_tready     = mt;
    endtask

    task automatic cycle();
        @(negedge clk);
        sample();
        @(posedge clk);
        model_step();
        #1;
        drive();
    endtask

    task automatic run(input int max_cyc);
        int n;
        n = 0;
        drive();
        while (busy() && n < max_cyc) begin
            cycle();
            n++;
        end
        chk("run_timeout", 64'(busy()), 64'(0));
    endtask

    // Assert reset at the current time, check outputs fall at once, then release after two edges.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, "_grant_valid"}, 64'(grant_valid), 64'(0));
        chk({tag, "_pkt_count"}, 64'(pkt_count), 64'(0));
        chk({tag, "_m_tvalid"}, 64'(m_tvalid), 64'(0));
        chk({tag, "_m_hdr_tvalid"}, 64'(m_hdr_tvalid), 64'(0));
        chk({tag, "_s_treadies"}, 64'({s_tready, s_hdr_tready}), 64'(0));
        clear_all();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_order(input string tag, input int exp[$]);
        chk({tag, "_ngrants"}, 64'(grants_q.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < grants_q.size(); i++) begin
            chk({tag, "_grant"}, 64'(grants_q[i]), 64'(exp[i]));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got stuck expected done");
        $fatal(1);
    end

    initial begin
        int total;
        int per_port[S];
        int seen[S];
        clear_all();
        gap_pct = 0; tr_mode = 0; bp_phase = 0;
        @(posedge clk);
        #1;
        do_reset("rst");

        // Single requester: port 2, 3 beats.
        grants_q.delete(); gaps_q.delete();
        fixed_len[2] = 3; pkts_left[2] = 1;
        run(50);
        check_order("single", '{2});
        chk("single_count", 64'(pkt_count), 64'(1));

        // Pointer now at 3: port 3 wins over port 0, then port 0.
        grants_q.delete(); gaps_q.delete();
        fixed_len[0] = 2; fixed_len[3] = 2; pkts_left[0] = 1; pkts_left[3] = 1;
        run(50);
        check_order("wrap", '{3, 0});
        chk("wrap_count", 64'(pkt_count), 64'(3));

        // Contention from reset: ports 0, 1, 3.
        do_reset("rst2");
        grants_q.delete(); gaps_q.delete();
        fixed_len[0] = 2; fixed_len[1] = 2; fixed_len[3] = 2;
        pkts_left[0] = 1; pkts_left[1] = 1; pkts_left[3] = 1;
        run(60);
        check_order("contend", '{0, 1, 3});
        chk("contend_ngaps", 64'(gaps_q.size()), 64'(2));
        foreach (gaps_q[i]) chk("contend_gap", 64'(gaps_q[i]), 64'(1));
        chk("contend_count", 64'(pkt_count), 64'(3));

        // Backpressure: m_axis_tready toggles 1,0,1,0 over a 4-beat payload.
        grants_q.delete(); gaps_q.delete();
        tr_mode = 1; bp_phase = 0;
        fixed_len[2] = 4; pkts_left[2] = 1;
        run(60);
        check_order("bp", '{2});
        chk("bp_count", 64'(pkt_count), 64'(4));

        // Single-beat payloads back to back on port 1.
        grants_q.delete(); gaps_q.delete();
        tr_mode = 0;
        fixed_len[1] = 1; pkts_left[1] = 2;
        run(30);
        check_order("one_beat", '{1, 1});
        chk("one_beat_gap", 64'(gaps_q.size() > 0 ? gaps_q[0] : -1), 64'(1));
        chk("one_beat_count", 64'(pkt_count), 64'(6));

        // Reset during beat 1 of a 4-beat packet, then a fresh packet from port 1.
        grants_q.delete(); gaps_q.delete();
        fixed_len[0] = 4; pkts_left[0] = 1;
        drive();
        for (int n = 0; n < 20 && !(owner == 0 && beats_left[0] == 3); n++) cycle();
        chk("mid_reached_beat1", 64'(beats_left[0]), 64'(3));
        #2;
        chk("mid_pre_tvalid", 64'(m_tvalid), 64'(1));
        do_reset("mid");
        grants_q.delete(); gaps_q.delete();
        fixed_len[1] = 2; pkts_left[1] = 1;
        run(30);
        check_order("after_rst", '{1});
        chk("after_rst_count", 64'(pkt_count), 64'(1));

        // Randomized traffic with valid gaps and random deparser backpressure.
        grants_q.delete(); gaps_q.delete();
        tr_mode = 2; gap_pct = 30;
        total = 0;
        for (int p = 0; p < S; p++) begin
            per_port[p] = int'($urandom_range(3, 8));
            pkts_left[p] = per_port[p];
            total += per_port[p];
            seen[p] = 0;
        end
        run(5000);
        chk("rand_count", 64'(pkt_count), 64'(1 + total));
        foreach (grants_q[i]) seen[grants_q[i]]++;
        for (int p = 0; p < S; p++) chk("rand_port_grants", 64'(seen[p]), 64'(per_port[p]));
        foreach (gaps_q[i]) chk("rand_gap_min", 64'(gaps_q[i] >= 1), 64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
